// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: configurable data width, parity and stop bits,
// 3-sample majority voting, and a valid/ready holding register with error flags.
module uart_rx_param #(
  parameter int CLOCK_FREQ = 38400000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int H       = OVERSAMPLE / 2;
  localparam int BC_W    = 4;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, BREAK_WAIT
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit a correct transmitter would send for word d.
  function automatic logic parity_expected(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic                 rx_p0, rxs;
  state_t               state, state_nxt;
  logic [TW-1:0]        tick_cnt;
  logic [SC_W-1:0]      sc;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 s_a, s_b;
  logic                 zero_so_far, par_bad, stop_bad;
  logic                 tick, eval, bit_val;
  logic                 enter_start, frame_done, brk, load_word;

  // Stage p0/p1: two-flop synchroniser for the asynchronous line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rxs   <= rx_p0;
    end
  end

  assign tick    = (tick_cnt == TW'(DIV - 1));
  assign eval    = tick && (sc == SC_W'(H + 1));
  assign bit_val = majority3(s_a, s_b, rxs);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst || soft_reset) state <= IDLE;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    enter_start = 1'b0;
    frame_done  = 1'b0;
    brk         = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt   = START;
          enter_start = 1'b1;
        end
      end
      START: begin
        if (eval) state_nxt = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (eval && bit_cnt == BC_W'(DATA_BITS - 1))
          state_nxt = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        if (eval) state_nxt = STOP;
      end
      STOP: begin
        if (eval) begin
          if (bit_cnt == '0 && zero_so_far && !bit_val) begin
            brk       = 1'b1;
            state_nxt = BREAK_WAIT;
          end else if (bit_cnt == BC_W'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
      BREAK_WAIT: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing and per-frame accumulators
  always_ff @(posedge clk) begin
    if (rst || soft_reset) begin
      tick_cnt    <= '0;
      sc          <= '0;
      bit_cnt     <= '0;
      zero_so_far <= 1'b1;
      par_bad     <= 1'b0;
      stop_bad    <= 1'b0;
    end else begin
      if (enter_start || tick) tick_cnt <= '0;
      else                     tick_cnt <= tick_cnt + 1'b1;

      if (state == IDLE)
        sc <= '0;
      else if (tick)
        sc <= (sc == SC_W'(OVERSAMPLE - 1)) ? '0 : sc + 1'b1;

      if (state_nxt != state)
        bit_cnt <= '0;
      else if (eval && (state == DATA || state == STOP))
        bit_cnt <= bit_cnt + 1'b1;

      if (enter_start) begin
        zero_so_far <= 1'b1;
        par_bad     <= 1'b0;
        stop_bad    <= 1'b0;
      end else if (eval) begin
        if (state == DATA || state == PAR) zero_so_far <= zero_so_far & ~bit_val;
        if (state == PAR)  par_bad  <= (bit_val != parity_expected(shreg));
        if (state == STOP) stop_bad <= stop_bad | ~bit_val;
      end
    end
  end

  // Sample capture and LSB-first shift register (data path, no reset needed)
  always_ff @(posedge clk) begin
    if (tick && sc == SC_W'(H - 1)) s_a <= rxs;
    if (tick && sc == SC_W'(H))     s_b <= rxs;
    if (state == DATA && eval)      shreg <= {bit_val, shreg[DATA_BITS-1:1]};
  end

  // A completed frame is dropped only when the held word is not being consumed
  assign load_word = frame_done && !soft_reset && !(valid && !ready);

  always_ff @(posedge clk) begin
    if (rst)            data <= '0;
    else if (load_word) data <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst || soft_reset) begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      break_det <= brk;
      if (load_word) begin
        valid      <= 1'b1;
        parity_err <= par_bad;
        frame_err  <= stop_bad | ~bit_val;
      end else if (valid && ready) begin
        valid      <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (frame_done && valid && !ready) overrun <= 1'b1;
    end
  end

endmodule
